// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gfx_pkg
// Brief    : Shared state encoding, default timing constants and helpers for
//            the HDMI pixel-clock PLL control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package gfx_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        RUN       = 3'd2,
        PS_SETUP  = 3'd3,
        PS_PULSE  = 3'd4,
        PS_GAP    = 3'd5
    } gfx_state_t;

    localparam int c_RST_CYCLES   = 16;
    localparam int c_LOCK_STABLE  = 256;
    localparam int c_LOCK_TIMEOUT = 8192;
    localparam int c_N_CHANNELS   = 4;
    localparam int c_CNT_W        = 8;
    localparam int c_STEP_SETUP   = 2;
    localparam int c_STEP_PULSE   = 4;
    localparam int c_STEP_GAP     = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gfx_sync2.sv
`default_nettype none
// ============================================================================
// Module   : gfx_sync2
// Brief    : Two-flop synchroniser for a single asynchronous level, reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the metastable first stage a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/gfx_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gfx_pll_ctrl
// Brief    : EHXPLLL control sequencer: PLL reset / lock qualification,
//            pixel-domain reset release, and dynamic phase-shift stepping.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_pll_ctrl
    import gfx_pkg::*;
#(
    parameter int RST_CYCLES   = c_RST_CYCLES,
    parameter int LOCK_STABLE  = c_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = c_LOCK_TIMEOUT,
    parameter int N_CHANNELS   = c_N_CHANNELS,
    parameter int CNT_W        = c_CNT_W,
    parameter int STEP_SETUP   = c_STEP_SETUP,
    parameter int STEP_PULSE   = c_STEP_PULSE,
    parameter int STEP_GAP     = c_STEP_GAP
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             gfx_rst,
    output logic             locked,
    output logic [7:0]       lock_lost_cnt,
    input  logic             ps_valid,
    output logic             ps_ready,
    input  logic [1:0]       ps_sel,
    input  logic             ps_dir,
    input  logic [CNT_W-1:0] ps_count,
    output logic             ps_err,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep
);

    // One shared down-counter times reset hold, lock timeout and step phases.
    localparam int c_TMR_MAX = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT),
                                       max_int(STEP_SETUP, max_int(STEP_PULSE, STEP_GAP)));
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_STB_W   = $clog2(LOCK_STABLE + 1);

    localparam logic [c_TMR_W-1:0] c_LD_RST   = c_TMR_W'(RST_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_LD_WAIT  = c_TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_LD_SETUP = c_TMR_W'(STEP_SETUP - 1);
    localparam logic [c_TMR_W-1:0] c_LD_PULSE = c_TMR_W'(STEP_PULSE - 1);
    localparam logic [c_TMR_W-1:0] c_LD_GAP   = c_TMR_W'(STEP_GAP - 1);
    localparam logic [c_STB_W-1:0] c_STB_LAST = c_STB_W'(LOCK_STABLE - 1);
    localparam logic [2:0]         c_NCH      = 3'(N_CHANNELS);

    gfx_state_t         r_state,     w_state;
    logic [c_TMR_W-1:0] r_tmr,       w_tmr;
    logic [c_STB_W-1:0] r_stable,    w_stable;
    logic [CNT_W-1:0]   r_steps,     w_steps;
    logic               r_pll_rst,   w_pll_rst;
    logic               r_gfx_rst,   w_gfx_rst;
    logic               r_locked,    w_locked;
    logic [7:0]         r_lost_cnt,  w_lost_cnt;
    logic               r_ps_ready,  w_ps_ready;
    logic               r_ps_err,    w_ps_err;
    logic [1:0]         r_phasesel,  w_phasesel;
    logic               r_phasedir,  w_phasedir;
    logic               r_phasestep, w_phasestep;

    logic w_lock_s;
    logic w_lock_fail;
    logic w_relock;
    logic w_sel_bad;

    gfx_sync2 u_lock_sync (
        .clk     (pclk),
        .rst     (rst),
        .i_async (pll_lock),
        .o_sync  (w_lock_s)
    );

    assign w_lock_fail = !w_lock_s && (r_state == RUN || r_state == PS_SETUP ||
                                       r_state == PS_PULSE || r_state == PS_GAP);
    assign w_relock    = relock_req && (r_state != RESET_PLL);
    assign w_sel_bad   = ({1'b0, ps_sel} >= c_NCH);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state     = r_state;
        w_tmr       = r_tmr;
        w_stable    = r_stable;
        w_steps     = r_steps;
        w_pll_rst   = r_pll_rst;
        w_gfx_rst   = r_gfx_rst;
        w_locked    = r_locked;
        w_lost_cnt  = r_lost_cnt;
        w_ps_ready  = 1'b0;
        w_ps_err    = r_ps_err;
        w_phasesel  = r_phasesel;
        w_phasedir  = r_phasedir;
        w_phasestep = r_phasestep;

        if (w_lock_fail || w_relock) begin
            // Abort whatever is running and restart the whole PLL sequence.
            w_state     = RESET_PLL;
            w_tmr       = c_LD_RST;
            w_stable    = '0;
            w_pll_rst   = 1'b1;
            w_gfx_rst   = 1'b1;
            w_locked    = 1'b0;
            w_phasestep = 1'b1;
            if (w_lock_fail && r_lost_cnt != 8'hFF)
                w_lost_cnt = r_lost_cnt + 8'd1;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_tmr == '0) begin
                        w_state   = WAIT_LOCK;
                        w_pll_rst = 1'b0;
                        w_tmr     = c_LD_WAIT;
                        w_stable  = '0;
                    end else begin
                        w_tmr = r_tmr - 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    w_stable = w_lock_s ? r_stable + 1'b1 : '0;
                    if (w_lock_s && r_stable == c_STB_LAST) begin
                        w_state   = RUN;
                        w_locked  = 1'b1;
                        w_gfx_rst = 1'b0;
                    end else if (r_tmr == '0) begin
                        w_state   = RESET_PLL;
                        w_pll_rst = 1'b1;
                        w_tmr     = c_LD_RST;
                    end else begin
                        w_tmr = r_tmr - 1'b1;
                    end
                end
                RUN: begin
                    w_ps_ready = 1'b1;
                    if (ps_valid && r_ps_ready) begin
                        if (w_sel_bad) begin
                            w_ps_err = 1'b1;
                        end else if (ps_count == '0) begin
                            w_ps_ready = 1'b0;
                        end else begin
                            w_ps_ready = 1'b0;
                            w_state    = PS_SETUP;
                            w_tmr      = c_LD_SETUP;
                            w_phasesel = ps_sel;
                            w_phasedir = ps_dir;
                            w_steps    = ps_count;
                        end
                    end
                end
                PS_SETUP: begin
                    if (r_tmr == '0) begin
                        w_state     = PS_PULSE;
                        w_phasestep = 1'b0;
                        w_tmr       = c_LD_PULSE;
                    end else begin
                        w_tmr = r_tmr - 1'b1;
                    end
                end
                PS_PULSE: begin
                    if (r_tmr == '0) begin
                        w_state     = PS_GAP;
                        w_phasestep = 1'b1;
                        w_tmr       = c_LD_GAP;
                        w_steps     = r_steps - 1'b1;
                    end else begin
                        w_tmr = r_tmr - 1'b1;
                    end
                end
                PS_GAP: begin
                    if (r_tmr != '0) begin
                        w_tmr = r_tmr - 1'b1;
                    end else if (r_steps == '0) begin
                        w_state = RUN;
                    end else begin
                        w_state     = PS_PULSE;
                        w_phasestep = 1'b0;
                        w_tmr       = c_LD_PULSE;
                    end
                end
                default: begin
                    w_state   = RESET_PLL;
                    w_tmr     = c_LD_RST;
                    w_pll_rst = 1'b1;
                end
            endcase
        end
    end

    // State, counters and registered outputs; rst overrides everything.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= RESET_PLL;
            r_tmr       <= c_LD_RST;
            r_stable    <= '0;
            r_steps     <= '0;
            r_pll_rst   <= 1'b1;
            r_gfx_rst   <= 1'b1;
            r_locked    <= 1'b0;
            r_lost_cnt  <= 8'd0;
            r_ps_ready  <= 1'b0;
            r_ps_err    <= 1'b0;
            r_phasesel  <= 2'd0;
            r_phasedir  <= 1'b1;
            r_phasestep <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_tmr       <= w_tmr;
            r_stable    <= w_stable;
            r_steps     <= w_steps;
            r_pll_rst   <= w_pll_rst;
            r_gfx_rst   <= w_gfx_rst;
            r_locked    <= w_locked;
            r_lost_cnt  <= w_lost_cnt;
            r_ps_ready  <= w_ps_ready;
            r_ps_err    <= w_ps_err;
            r_phasesel  <= w_phasesel;
            r_phasedir  <= w_phasedir;
            r_phasestep <= w_phasestep;
        end
    end

    assign pll_rst       = r_pll_rst;
    assign gfx_rst       = r_gfx_rst;
    assign locked        = r_locked;
    assign lock_lost_cnt = r_lost_cnt;
    assign ps_ready      = r_ps_ready;
    assign ps_err        = r_ps_err;
    assign phasesel      = r_phasesel;
    assign phasedir      = r_phasedir;
    assign phasestep     = r_phasestep;

endmodule
`default_nettype wire
